ram_arbiter: RTL and testbench

- Sequences and shares the single 8-bit RAM between two requesters: instruction fetch (program section, read-only) and data load/store (data section, read/write).
- Drives the RAM's address-load, write-enable, read-select and output-enable controls.
- Respects the RAM's registered-address / asynchronous-read timing.
- Sits between the control unit's fetch/memory stages and the RAM block.

---
 rtl/ram_arbiter.sv | 143 ++++++++++++++
 tb/tb_ram_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one 8-bit RAM between instruction fetch (program section,
// read-only) and data load/store (data section, read/write).
//
// Each transaction takes three cycles: IDLE (grant and latch), ADDR (RAM address
// register loads on the closing edge), ACCESS (asynchronous read captured, or
// write strobe). The winner's ack pulses in the following IDLE cycle, so a request
// still held in that cycle starts again at once.
//
// Build option: define RAM_ARB_ROUND_ROBIN_EN to alternate grants when both
// requests are pending. Otherwise data always has priority over fetch.
//
// Ports:
//   i_clk, i_reset                    clock, synchronous active-high reset
//   i_fetchReq/i_fetchAddress         fetch request and program address
//   o_fetchAck/o_fetchData            fetch completion pulse and held byte
//   i_dataReq/i_dataAddress/i_dataWe  data request, address, write select
//   i_dataWriteData                   data write byte
//   o_dataAck/o_dataReadData          data completion pulse and held read byte
//   o_ramAddress/o_ramAddressEn       RAM address and address-register load
//   o_ramWriteData/o_ramWriteEn       RAM write byte and strobe
//   o_ramReadDataSelect               1 = data section, 0 = program section
//   o_ramOutEnable                    RAM output transceiver enable
//   i_ramReadData                     RAM read bus
//   o_busy                            high whenever not in IDLE
module ram_arbiter #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_fetchReq,
  input  logic [ADDR_WIDTH-1:0] i_fetchAddress,
  output logic                  o_fetchAck,
  output logic [DATA_WIDTH-1:0] o_fetchData,
  input  logic                  i_dataReq,
  input  logic [ADDR_WIDTH-1:0] i_dataAddress,
  input  logic                  i_dataWe,
  input  logic [DATA_WIDTH-1:0] i_dataWriteData,
  output logic                  o_dataAck,
  output logic [DATA_WIDTH-1:0] o_dataReadData,
  output logic [ADDR_WIDTH-1:0] o_ramAddress,
  output logic                  o_ramAddressEn,
  output logic [DATA_WIDTH-1:0] o_ramWriteData,
  output logic                  o_ramWriteEn,
  output logic                  o_ramReadDataSelect,
  output logic                  o_ramOutEnable,
  input  logic [DATA_WIDTH-1:0] i_ramReadData,
  output logic                  o_busy
);

  typedef enum logic [1:0] {StIdle, StAddr, StAccess} state_e;

  state_e                state_q;
  logic                  is_data_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  grant_data;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  // 1 = data was served last; reset value favours data on the first contention.
  logic last_data_q;

  always_comb begin
    grant_data = i_dataReq && (!i_fetchReq || !last_data_q);
  end
`else
  always_comb begin
    grant_data = i_dataReq;
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q             <= StIdle;
      is_data_q           <= 1'b0;
      we_q                <= 1'b0;
      wdata_q             <= '0;
      o_fetchAck          <= 1'b0;
      o_fetchData         <= '0;
      o_dataAck           <= 1'b0;
      o_dataReadData      <= '0;
      o_ramAddress        <= '0;
      o_ramAddressEn      <= 1'b0;
      o_ramWriteData      <= '0;
      o_ramWriteEn        <= 1'b0;
      o_ramReadDataSelect <= 1'b0;
      o_ramOutEnable      <= 1'b0;
      o_busy              <= 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      last_data_q         <= 1'b0;
`endif
    end else begin
      o_fetchAck <= 1'b0;
      o_dataAck  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_dataReq || i_fetchReq) begin
            // Requests are latched here so later input changes cannot disturb
            // the transaction in flight.
            is_data_q      <= grant_data;
            we_q           <= grant_data && i_dataWe;
            wdata_q        <= i_dataWriteData;
            o_ramAddress   <= grant_data ? i_dataAddress : i_fetchAddress;
            o_ramAddressEn <= 1'b1;
            o_busy         <= 1'b1;
            state_q        <= StAddr;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            last_data_q    <= grant_data;
`endif
          end
        end
        StAddr: begin
          o_ramAddress        <= '0;
          o_ramAddressEn      <= 1'b0;
          o_ramReadDataSelect <= is_data_q;
          o_ramOutEnable      <= !we_q;
          o_ramWriteEn        <= we_q;
          o_ramWriteData      <= we_q ? wdata_q : '0;
          state_q             <= StAccess;
        end
        StAccess: begin
          o_ramReadDataSelect <= 1'b0;
          o_ramOutEnable      <= 1'b0;
          o_ramWriteEn        <= 1'b0;
          o_ramWriteData      <= '0;
          o_busy              <= 1'b0;
          state_q             <= StIdle;
          if (is_data_q) begin
            o_dataAck <= 1'b1;
            if (!we_q) begin
              o_dataReadData <= i_ramReadData;
            end
          end else begin
            o_fetchAck  <= 1'b1;
            o_fetchData <= i_ramReadData;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       fetch_req;
  logic [7:0] fetch_addr;
  logic       fetch_ack;
  logic [7:0] fetch_data;
  logic       data_req;
  logic [7:0] data_addr;
  logic       data_we;
  logic [7:0] data_wdata;
  logic       data_ack;
  logic [7:0] data_rdata;
  logic [7:0] ram_addr;
  logic       ram_addr_en;
  logic [7:0] ram_wdata;
  logic       ram_we;
  logic       ram_sel;
  logic       ram_oe;
  logic [7:0] ram_rdata;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .i_clk              (clk),
    .i_reset            (reset),
    .i_fetchReq         (fetch_req),
    .i_fetchAddress     (fetch_addr),
    .o_fetchAck         (fetch_ack),
    .o_fetchData        (fetch_data),
    .i_dataReq          (data_req),
    .i_dataAddress      (data_addr),
    .i_dataWe           (data_we),
    .i_dataWriteData    (data_wdata),
    .o_dataAck          (data_ack),
    .o_dataReadData     (data_rdata),
    .o_ramAddress       (ram_addr),
    .o_ramAddressEn     (ram_addr_en),
    .o_ramWriteData     (ram_wdata),
    .o_ramWriteEn       (ram_we),
    .o_ramReadDataSelect(ram_sel),
    .o_ramOutEnable     (ram_oe),
    .i_ramReadData      (ram_rdata),
    .o_busy             (busy)
  );

  // RAM model: registered address, asynchronous read. Program section content is
  // addr ^ 0xB7; data section initialises to addr + 0x11.
  logic [7:0] data_mem [256];
  logic [7:0] ram_addr_q;
  logic       mem_init;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) data_mem[i] <= 8'(i + 8'h11);
      ram_addr_q <= 8'h00;
    end else begin
      if (ram_addr_en) ram_addr_q <= ram_addr;
      if (ram_we) data_mem[ram_addr_q] <= ram_wdata;
    end
  end

  assign ram_rdata = ram_sel ? data_mem[ram_addr_q] : (ram_addr_q ^ 8'hB7);

  logic [38:0] all_outs;
  assign all_outs = {fetch_ack, fetch_data, data_ack, data_rdata, ram_addr, ram_addr_en,
                     ram_wdata, ram_we, ram_sel, ram_oe, busy};

  typedef struct {
    string      name;
    logic       is_data;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction from IDLE, checking every cycle; returns in IDLE with acks low.
  task automatic do_txn(input vec_t v);
    if (v.is_data) begin
      data_req = 1'b1; data_addr = v.addr; data_we = v.we; data_wdata = v.wdata;
    end else begin
      fetch_req = 1'b1; fetch_addr = v.addr;
    end
    tick();
    check({v.name, ":addr_en"}, 64'(ram_addr_en), 64'd1);
    check({v.name, ":addr"}, 64'(ram_addr), 64'(v.addr));
    check({v.name, ":busy"}, 64'(busy), 64'd1);
    check({v.name, ":addr_we_oe"}, 64'({ram_we, ram_oe}), 64'd0);
    tick();
    check({v.name, ":acc_en"}, 64'(ram_addr_en), 64'd0);
    check({v.name, ":sel"}, 64'(ram_sel), 64'(v.is_data));
    check({v.name, ":oe"}, 64'(ram_oe), 64'(!v.we));
    check({v.name, ":we"}, 64'(ram_we), 64'(v.we));
    check({v.name, ":wdata"}, 64'(ram_wdata), v.we ? 64'(v.wdata) : 64'd0);
    check({v.name, ":acc_ack"}, 64'({fetch_ack, data_ack}), 64'd0);
    tick();
    check({v.name, ":acks"}, 64'({fetch_ack, data_ack}), 64'({!v.is_data, v.is_data}));
    if (!v.we) begin
      check({v.name, ":rdata"}, v.is_data ? 64'(data_rdata) : 64'(fetch_data), 64'(v.rdata));
    end
    check({v.name, ":idle_ctl"}, 64'({busy, ram_addr_en, ram_we, ram_oe, ram_sel}), 64'd0);
    fetch_req = 1'b0; data_req = 1'b0; data_we = 1'b0;
    tick();
    check({v.name, ":ack_pulse"}, 64'({fetch_ack, data_ack}), 64'd0);
  endtask

  logic grant_is_data [4];
  int   grant_cyc [4];
  int   n_grants;
  logic exp_is_data [4];

  initial begin
    vecs[0] = '{"fetch12",   1'b0, 1'b0, 8'h12, 8'h00, 8'hA5};
    vecs[1] = '{"wr40",      1'b1, 1'b1, 8'h40, 8'h3C, 8'h00};
    vecs[2] = '{"rd40",      1'b1, 1'b0, 8'h40, 8'h00, 8'h3C};
    vecs[3] = '{"fetch00",   1'b0, 1'b0, 8'h00, 8'h00, 8'hB7};
    vecs[4] = '{"fetchff",   1'b0, 1'b0, 8'hFF, 8'h00, 8'h48};
    vecs[5] = '{"rd05",      1'b1, 1'b0, 8'h05, 8'h00, 8'h16};
    vecs[6] = '{"wrff",      1'b1, 1'b1, 8'hFF, 8'h81, 8'h00};
    vecs[7] = '{"rdff",      1'b1, 1'b0, 8'hFF, 8'h00, 8'h81};
    vecs[8] = '{"fetch12b",  1'b0, 1'b0, 8'h12, 8'h00, 8'hA5};

`ifdef RAM_ARB_ROUND_ROBIN_EN
    exp_is_data = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_is_data = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif

    reset = 1'b1; mem_init = 1'b1;
    fetch_req = 1'b0; fetch_addr = 8'h00;
    data_req = 1'b0; data_addr = 8'h00; data_we = 1'b0; data_wdata = 8'h00;
    repeat (3) tick();
    check("reset_outs", 64'(all_outs), 64'd0);
    reset = 1'b0; mem_init = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) do_txn(vecs[i]);

    // Simultaneous requests held continuously, starting from a fresh reset.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    fetch_req = 1'b1; fetch_addr = 8'h12;
    data_req = 1'b1; data_addr = 8'h05; data_we = 1'b0;
    n_grants = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if ((data_ack || fetch_ack) && n_grants < 4) begin
        grant_is_data[n_grants] = data_ack;
        grant_cyc[n_grants] = c;
        n_grants++;
      end
      if (c == 12) begin
        fetch_req = 1'b0; data_req = 1'b0;
      end
    end
    check("sim_count", 64'(n_grants), 64'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < n_grants) begin
        check($sformatf("sim_grant%0d", k), 64'(grant_is_data[k]), 64'(exp_is_data[k]));
        check($sformatf("sim_cyc%0d", k), 64'(grant_cyc[k]), 64'(3 * (k + 1)));
      end
    end
    tick();

    // Reset while a write is in ADDR: no strobe, no ack, memory untouched.
    data_req = 1'b1; data_addr = 8'h50; data_we = 1'b1; data_wdata = 8'h99;
    tick();
    check("rstaddr_in_addr", 64'(ram_addr_en), 64'd1);
    reset = 1'b1; data_req = 1'b0; data_we = 1'b0;
    tick();
    check("rstaddr_outs", 64'(all_outs), 64'd0);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("rstaddr_quiet%0d", c), 64'({fetch_ack, data_ack, ram_we}), 64'd0);
    end
    do_txn('{"rstaddr_rd50", 1'b1, 1'b0, 8'h50, 8'h00, 8'h61});

    // Reset while a write is in ACCESS.
    data_req = 1'b1; data_addr = 8'h60; data_we = 1'b1; data_wdata = 8'h77;
    tick();
    tick();
    check("rstacc_we", 64'(ram_we), 64'd1);
    reset = 1'b1; data_req = 1'b0; data_we = 1'b0;
    tick();
    check("rstacc_outs", 64'(all_outs), 64'd0);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("rstacc_quiet%0d", c), 64'({fetch_ack, data_ack}), 64'd0);
    end
    do_txn('{"rstacc_fetch", 1'b0, 1'b0, 8'h12, 8'h00, 8'hA5});

    // Data request held through its ack with a new address.
    data_req = 1'b1; data_addr = 8'h40; data_we = 1'b0;
    tick(); tick(); tick();
    check("hold_ack1", 64'(data_ack), 64'd1);
    check("hold_rdata1", 64'(data_rdata), 64'h3C);
    data_addr = 8'h41;
    tick();
    check("hold_addr_en2", 64'(ram_addr_en), 64'd1);
    check("hold_addr2", 64'(ram_addr), 64'h41);
    tick(); tick();
    check("hold_ack2", 64'(data_ack), 64'd1);
    check("hold_rdata2", 64'(data_rdata), 64'h52);
    data_req = 1'b0;
    tick();
    check("hold_done", 64'({data_ack, busy}), 64'd0);

    // Fetch address changed while the transaction is in ACCESS.
    fetch_req = 1'b1; fetch_addr = 8'h20;
    tick(); tick();
    check("mid_in_access", 64'(ram_oe), 64'd1);
    fetch_addr = 8'h21;
    tick();
    check("mid_ack", 64'(fetch_ack), 64'd1);
    check("mid_fdata", 64'(fetch_data), 64'h97);
    check("mid_dheld", 64'(data_rdata), 64'h52);
    fetch_req = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
